smpl_mem_responder: RTL and testbench

//  Memory-side responder for the smpl_core bus: serves instruction fetches (iaddr/idata) and data

---
 rtl/smpl_mem_responder.sv | 133 +++++++++++++
 tb/tb_smpl_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/smpl_mem_responder.sv
// Shared single-ported word memory serving smpl_core fetches and data accesses with wait states.
// Optional write protection of the low address range is enabled by defining SMPL_MEM_WPROT_EN.
module smpl_mem_responder #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PROT_LIMIT  = 'h0400,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  output logic              iready,
  input  logic              renbl,
  input  logic              wenbl,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] datao,
  output logic [DATA_W-1:0] datai,
  output logic              dready,
  output logic              busy,
  output logic              werr
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

`ifdef SMPL_MEM_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic              fair;
  logic              lat_fetch, lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic              data_req, any_req, grant_fetch;
  logic              acc_fetch, acc_wr, enter_resp, prot_hit, commit;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  assign data_req    = renbl | wenbl;
  assign any_req     = ireq | data_req;
  assign grant_fetch = ireq & (~data_req | fair);

  // With zero wait states the edge that accepts a request also performs it, so the
  // access is taken from the live inputs in IDLE and from the latched copy afterwards.
  always_comb begin
    acc_fetch = lat_fetch;
    acc_wr    = lat_wr;
    acc_addr  = lat_addr;
    acc_data  = lat_data;
    if (state == ST_IDLE) begin
      acc_fetch = grant_fetch;
      acc_wr    = ~grant_fetch & wenbl;
      acc_addr  = grant_fetch ? iaddr : daddr;
      acc_data  = datao;
    end
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (any_req) state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 3'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == ST_RESP);
  assign prot_hit   = acc_wr & (acc_addr < ADDR_W'(PROT_LIMIT));
  assign commit     = enter_resp & acc_wr & ~(WPROT_EN & prot_hit);

  // NOTE: the array has no reset; gating with reset keeps a write from landing while held in reset.
  always_ff @(posedge clock) begin
    if (reset && commit) mem[acc_addr] <= acc_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      fair      <= 1'b0;
      lat_fetch <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      idata     <= '0;
      datai     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (state == ST_IDLE && any_req) begin
        cnt       <= WS_LOAD;
        lat_fetch <= acc_fetch;
        lat_wr    <= acc_wr;
        lat_addr  <= acc_addr;
        lat_data  <= acc_data;
        if (grant_fetch)  fair <= 1'b0;
        else if (ireq)    fair <= 1'b1;
      end
      if (enter_resp && !acc_wr) begin
        if (acc_fetch) idata <= mem[acc_addr];
        else           datai <= mem[acc_addr];
      end
    end
  end

`ifdef SMPL_MEM_WPROT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     werr <= 1'b0;
    else if (enter_resp && prot_hit) werr <= 1'b1;
  end
`else
  assign werr = 1'b0;
`endif

  assign busy   = (state != ST_IDLE);
  assign iready = (state == ST_RESP) &  lat_fetch;
  assign dready = (state == ST_RESP) & ~lat_fetch;

endmodule

// File: tb/tb_smpl_mem_responder.sv
// Directed self-checking bench for smpl_mem_responder (WAIT_STATES=1).
// Protection checks run when SMPL_MEM_WPROT_EN is defined; data addresses then move above the limit.
module tb_smpl_mem_responder;

`ifdef SMPL_MEM_WPROT_EN
  localparam logic [12:0] BASE = 13'h0400;
`else
  localparam logic [12:0] BASE = 13'h0000;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ireq, renbl, wenbl;
  logic [12:0] iaddr, daddr;
  logic [15:0] datao;
  logic [15:0] idata, datai;
  logic        iready, dready, busy, werr;

  int checks   = 0;
  int failures = 0;

  smpl_mem_responder #(.ADDR_W(13), .DATA_W(16), .WAIT_STATES(1), .PROT_LIMIT('h0400)) dut (
    .clock(clock), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .idata(idata), .iready(iready),
    .renbl(renbl), .wenbl(wenbl), .daddr(daddr), .datao(datao),
    .datai(datai), .dready(dready), .busy(busy), .werr(werr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Advances until a ready pulse is seen; lat is the number of edges taken, 0 on timeout.
  task automatic wait_ready(output int lat, output logic gi, output logic gd);
    lat = 0; gi = 1'b0; gd = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (iready || dready) begin
        lat = k; gi = iready; gd = dready;
        break;
      end
    end
  endtask

  task automatic write_word(input string tag, input logic [12:0] a, input logic [15:0] d);
    int lat; logic gi, gd;
    wenbl = 1'b1; daddr = a; datao = d;
    wait_ready(lat, gi, gd);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_dready"}, {gi, gd}, 2'b01);
    wenbl = 1'b0;
    step();
    check({tag, "_pulse"}, {dready, busy}, 2'b00);
  endtask

  task automatic read_word(input string tag, input logic [12:0] a, input logic [15:0] exp);
    int lat; logic gi, gd;
    renbl = 1'b1; daddr = a;
    wait_ready(lat, gi, gd);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_dready"}, {gi, gd}, 2'b01);
    check({tag, "_datai"}, datai, exp);
    renbl = 1'b0;
    step();
    check({tag, "_held"}, {dready, datai}, {1'b0, exp});
  endtask

  initial begin
    int lat; logic gi, gd, seen;
    reset = 1'b0; ireq = 1'b0; renbl = 1'b0; wenbl = 1'b0;
    iaddr = '0; daddr = '0; datao = '0;

    // 1: reset with random requests
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      ireq = 1'($urandom); renbl = 1'($urandom); wenbl = 1'($urandom);
      iaddr = 13'($urandom); daddr = 13'($urandom); datao = 16'($urandom);
      step();
      check("reset_outputs", {idata, datai, iready, dready, busy, werr}, '0);
    end
    reset = 1'b1; ireq = 1'b0; renbl = 1'b0; wenbl = 1'b0;
    step();
    step();
    check("post_reset_idle", {iready, dready, busy}, 3'b000);

    // 2: write then read back
    write_word("wr_0800", 13'h0800, 16'hA5C3);
    read_word("rd_0800", 13'h0800, 16'hA5C3);

    // 3: fetch sees prior write; datai untouched by fetch
    write_word("wr_code", BASE + 13'h0001, 16'h2001);
    ireq = 1'b1; iaddr = BASE + 13'h0001;
    wait_ready(lat, gi, gd);
    check("fetch_lat", lat, 2);
    check("fetch_ready", {gi, gd}, 2'b10);
    check("fetch_idata", idata, 16'h2001);
    check("fetch_datai_kept", datai, 16'hA5C3);
    ireq = 1'b0;
    step();
    check("fetch_pulse", {iready, idata}, {1'b0, 16'h2001});

    // 4: read and write together act as a write
    renbl = 1'b1; wenbl = 1'b1; daddr = BASE + 13'h0010; datao = 16'h1234;
    wait_ready(lat, gi, gd);
    check("rw_lat", lat, 2);
    check("rw_ready", {gi, gd}, 2'b01);
    check("rw_datai_kept", datai, 16'hA5C3);
    renbl = 1'b0; wenbl = 1'b0;
    step();
    check("rw_single_pulse", {dready, busy}, 2'b00);
    read_word("rd_0010", BASE + 13'h0010, 16'h1234);

    // arbitration: data wins first, then the fetch that lost wins
    ireq = 1'b1; iaddr = BASE + 13'h0001; renbl = 1'b1; daddr = 13'h0800;
    wait_ready(lat, gi, gd);
    check("arb1_data_wins", {gi, gd}, 2'b01);
    check("arb1_datai", datai, 16'hA5C3);
    wait_ready(lat, gi, gd);
    check("arb2_lat", lat, 3);
    check("arb2_fetch_wins", {gi, gd}, 2'b10);
    check("arb2_idata", idata, 16'h2001);
    ireq = 1'b0; daddr = BASE + 13'h0010;
    wait_ready(lat, gi, gd);
    check("arb3_data_alone", {gi, gd}, 2'b01);
    check("arb3_datai", datai, 16'h1234);
    ireq = 1'b1;
    wait_ready(lat, gi, gd);
    check("arb4_data_wins_again", {gi, gd, lat[3:0]}, {2'b01, 4'd3});
    renbl = 1'b0;
    wait_ready(lat, gi, gd);
    check("arb5_fetch", {gi, gd, lat[3:0]}, {2'b10, 4'd3});
    ireq = 1'b0;
    step();
    check("arb_idle", {iready, dready, busy}, 3'b000);

    // 5: reset during WAIT abandons a write
    write_word("wr_beef", BASE + 13'h0020, 16'hBEEF);
    wenbl = 1'b1; daddr = BASE + 13'h0020; datao = 16'h0000;
    step();
    check("abort_in_wait", {busy, dready}, 2'b10);
    reset = 1'b0;
    #1;
    check("abort_reset_outputs", {busy, dready, datai}, '0);
    wenbl = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | dready | iready;
    end
    check("abort_no_ready", seen, 1'b0);
    read_word("rd_beef", BASE + 13'h0020, 16'hBEEF);

    // 6: write protection
`ifdef SMPL_MEM_WPROT_EN
    check("werr_clear", werr, 1'b0);
    write_word("wr_prot", 13'h0003, 16'hFFFF);
    check("werr_set", werr, 1'b1);
    renbl = 1'b1; daddr = 13'h0003;
    wait_ready(lat, gi, gd);
    check("rd_prot_ready", {gi, gd, lat[3:0]}, {2'b01, 4'd2});
    check("rd_prot_unchanged", (datai === 16'hFFFF), 1'b0);
    renbl = 1'b0;
    step();
    write_word("wr_0400", 13'h0400, 16'h5A5A);
    read_word("rd_0400", 13'h0400, 16'h5A5A);
    check("werr_sticky", werr, 1'b1);
`else
    write_word("wr_0003", 13'h0003, 16'hFFFF);
    check("werr_tied", werr, 1'b0);
    read_word("rd_0003", 13'h0003, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
